rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
Round-robin arbiter and sequencer for a shared N:1 data mux. It owns the mux select: it grants one requester at a time, locks the grant for a whole multi-beat packet, and steers that requester's data and handshake onto a single downstream valid/ready port. It sits in front of any shared resource fed from several sources through the team's mux.

Parameters:
N_REQ, 4, number of requesters; legal range 1..16
DATA_W, 8, data width per requester and at the output
IDX_W, max(1, clog2(N_REQ)), width of grant index (derived, not overridden)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-requester beat valid
req_last  input  N_REQ  per-requester end-of-packet flag, meaningful when req_valid is 1
req_data  input  N_REQ*DATA_W  packed requester data; requester i in bits [i*DATA_W +: DATA_W]
req_ready  output  N_REQ  per-requester accept
out_valid  output  1  downstream beat valid
out_last  output  1  downstream end-of-packet
out_data  output  DATA_W  downstream data (mux output)
out_ready  input  1  downstream accept
grant_valid  output  1  a grant is currently held
grant_idx  output  IDX_W  index of held grant (mux select)

Behaviour:
- Reset: FSM in IDLE; grant_idx = 0; last_grant = N_REQ-1, so requester 0 has first priority; grant_valid = 0. Reset overrides all other inputs in the same cycle.
- FSM states: IDLE and BUSY.
- IDLE, no req_valid: stay in IDLE.
- IDLE, any req_valid: winner is the first i with req_valid[i]=1, scanning (last_grant+1) mod N_REQ upward with wrap. Register grant_idx = winner; go to BUSY.
- Arbitration latency: exactly 1 cycle. A request raised in cycle t can transfer its first beat no earlier than t+1.
- While in IDLE: out_valid = 0, out_last = 0, req_ready = 0 for all requesters, out_data = 0.
- BUSY, with g = grant_idx (combinational pass-through, no added latency):
  - out_valid = req_valid[g]; out_last = req_last[g]; out_data = req_data[g].
  - req_ready[g] = out_ready; req_ready is 0 for every other requester.
- Beat transfer happens when req_valid[g] && out_ready.
- If a beat transfers with req_last[g] = 1: last_grant = g; go to IDLE. The next arbitration takes one cycle, so there is one idle cycle between packets.
- Grant lock: while in BUSY, requests from other requesters are ignored, whatever their priority. If the granted requester drops req_valid mid-packet, the grant is held and out_valid stays 0 until it resumes. There is no timeout.
- Downstream backpressure (out_ready = 0): no transfer. Output values follow the granted requester, which must hold its data stable per valid/ready rules.
- Single-beat packet (req_last = 1 on the first beat) is legal.
- N_REQ = 1: the scan always picks requester 0. The IDLE/BUSY cycle still applies.
- Reset mid-packet: the packet is abandoned; IDLE and last_grant = N_REQ-1 on the next cycle. Upstream is responsible for recovery.
- Fairness: each requester with continuous requests is granted within N_REQ packets.
- The x/z on valid or select is not checked in RTL; the bench asserts that grant_idx and req_ready are never X after reset.

Decomposition:
- Shared package rr_mux_pkg holds:
  - the enum arb_state_t {IDLE, BUSY};
  - function idx_width(n), returning max(1, clog2(n));
  - function rr_next(last, n), returning (last+1) mod n.
- One sub-module: rr_pick. It is purely combinational. Inputs are a request vector and a start index; outputs are the winner index and an any-request flag. It rotates, applies a priority encoder, then un-rotates.
- The top level holds the FSM, grant_idx/last_grant registers, and the N:1 data/handshake steering.

Test Plan:
- Reset, then req_valid = 4'b0001 with req_last = 1 → grant_idx = 0 after 1 cycle; one beat out with out_data = req_data[0]; FSM returns to IDLE.
- Continuous req_valid = 4'b1111, single-beat packets, out_ready = 1 → grant order 0,1,2,3,0; one idle cycle between each packet.
- Requester 2 sends a 3-beat packet while requester 1 requests mid-packet → all 3 beats from requester 2 complete before requester 1 is granted; req_ready[1] = 0 throughout.
- Granted requester drops req_valid for 2 cycles mid-packet → out_valid = 0 for those cycles; grant_idx unchanged; packet then completes.
- out_ready = 0 for 3 cycles during a beat → no transfer, req_ready[g] = 0, out_data stable; the transfer completes when out_ready returns to 1.
- Assert reset mid-packet with requester 3 granted → next cycle grant_valid = 0 and all req_ready = 0. With req_valid = 4'b1001 afterwards, requester 0 wins.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package rr_mux_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Round-robin successor of last, wrapping at n.
  function automatic int rr_next(input int last, input int n);
    return (last + 1) % n;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Rotating priority pick: first asserted request at or after start, with wrap.
module rr_pick
  import rr_mux_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N_REQ);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   k;
  logic [IDX_W:0]     sum;

  // Rotate so that bit 0 of rot is requester 'start'.
  always_comb begin
    dbl = {req, req} >> start;
    rot = dbl[N_REQ-1:0];
  end

  // Lowest-index priority encode on the rotated vector, then un-rotate.
  always_comb begin
    k = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) k = IDX_W'(i);
    end
    sum = {1'b0, start} + {1'b0, k};
    if (sum >= N_L) sum = sum - N_L;
    winner = sum[IDX_W-1:0];
    any    = |req;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning an N:1 mux; grant is locked for a whole packet.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int  N_REQ  = 4,
  parameter int  DATA_W = 8,
  localparam int IDX_W  = idx_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready,
  output logic                    grant_valid,
  output logic [IDX_W-1:0]        grant_idx
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] start, winner;
  logic             any_req;
  logic             beat_xfer;

  logic [DATA_W-1:0] data_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  assign start = IDX_W'(rr_next(int'(last_grant_q), N_REQ));

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (req_valid),
    .start  (start),
    .winner (winner),
    .any    (any_req)
  );

  assign grant_valid = (state_q == BUSY);
  assign grant_idx   = grant_idx_q;
  assign beat_xfer   = grant_valid && req_valid[grant_idx_q] && out_ready;

  // Steer the granted requester onto the downstream port; silent when idle.
  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    if (grant_valid) begin
      out_valid              = req_valid[grant_idx_q];
      out_last               = req_last[grant_idx_q];
      out_data               = data_arr[grant_idx_q];
      req_ready[grant_idx_q] = out_ready;
    end
  end

  // Arbitrate from IDLE; release the grant on the last beat of the packet.
  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_idx_d = winner;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (beat_xfer && req_last[grant_idx_q]) begin
          last_grant_d = grant_idx_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset leaves requester 0 with first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Random-stimulus bench: packet-level requester model plus scoreboard monitor.
module tb_rr_mux_arbiter;

  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int IW     = 2;
  localparam int NCYC   = 3000;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, req_last, req_ready;
  logic [N*DW-1:0]   req_data;
  logic              out_valid, out_last, out_ready;
  logic [DW-1:0]     out_data;
  logic              grant_valid;
  logic [IW-1:0]     grant_idx;

  rr_mux_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_last(out_last), .out_data(out_data),
    .out_ready(out_ready),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          idx;
    logic [DW-1:0] data;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Values the monitor needs for the current cycle, published by the driver.
  int  cyc      = 0;
  bit  armed    = 0;
  bit  cur_busy = 0;
  int  cur_g    = 0;
  bit  after_rst = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Driver and reference model: requesters hold a beat until the model says it moved.
  initial begin : driver
    bit            hv [N];
    logic [DW-1:0] hd [N];
    bit            hl [N];
    int            rem [N];
    bit            busy_m;
    int            g_m, last_m, p_req, p_rdy;
    bit            prev_rst, rdy, found;
    beat_t         b;

    reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
    busy_m = 0; g_m = 0; last_m = N - 1; prev_rst = 1;
    for (int i = 0; i < N; i++) begin hv[i] = 0; hd[i] = '0; hl[i] = 0; rem[i] = 0; end

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cyc = c;
      if (c < 1000)      begin p_req = 90; p_rdy = 100; end
      else if (c < 2000) begin p_req = 40; p_rdy = 60;  end
      else               begin p_req = 70; p_rdy = 30;  end

      if (c < 2 || $urandom_range(299) == 0) begin
        reset = 1'b1;
        req_valid = '0; req_last = '0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin hv[i] = 0; rem[i] = 0; end
        busy_m = 0; last_m = N - 1;
        cur_busy = 0; prev_rst = 1; armed = 1;
        continue;
      end
      reset = 1'b0;

      for (int i = 0; i < N; i++) begin
        if (!hv[i] && $urandom_range(99) < p_req) begin
          if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
          hv[i] = 1;
          hd[i] = DW'($urandom);
          hl[i] = (rem[i] == 1);
        end
      end
      rdy = ($urandom_range(99) < p_rdy);

      for (int i = 0; i < N; i++) begin
        req_valid[i] = hv[i];
        req_last[i]  = hv[i] ? hl[i] : 1'b0;
        req_data[i*DW +: DW] = hd[i];
      end
      out_ready = rdy;

      cur_busy  = busy_m;
      cur_g     = g_m;
      after_rst = prev_rst;
      prev_rst  = 0;

      if (!busy_m) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && hv[(last_m + k) % N]) begin
            g_m = (last_m + k) % N;
            found = 1;
          end
        end
        busy_m = found;
      end else if (hv[g_m] && rdy) begin
        b.cyc = c; b.idx = g_m; b.data = hd[g_m]; b.last = hl[g_m];
        sb.push_back(b);
        hv[g_m] = 0;
        rem[g_m]--;
        if (hl[g_m]) begin busy_m = 0; last_m = g_m; end
      end
    end

    @(negedge clk);
    #5;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d beats outstanding expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Monitor: samples mid-cycle, checks steering and pops expected beats on transfer.
  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      #3;
      if (armed && !reset) begin
        if (after_rst) chk("grant_idx_after_reset", 32'(grant_idx), 0);
        chk("no_x_grant_ready", 32'($isunknown({grant_idx, req_ready})), 0);
        chk("grant_valid", 32'(grant_valid), 32'(cur_busy));
        if (cur_busy) begin
          chk("grant_idx", 32'(grant_idx), cur_g);
          chk("req_ready", 32'(req_ready), out_ready ? (32'd1 << cur_g) : 32'd0);
          chk("out_valid", 32'(out_valid), 32'(req_valid[cur_g]));
        end else begin
          chk("idle_out", 32'({out_valid, out_last, out_data}), 0);
          chk("idle_ready", 32'(req_ready), 0);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat @cyc %0d: got beat from %0d expected none", cyc, grant_idx);
          end else begin
            e = sb.pop_front();
            chk("beat_cycle", cyc, e.cyc);
            chk("beat_idx", 32'(grant_idx), e.idx);
            chk("beat_data", 32'(out_data), 32'(e.data));
            chk("beat_last", 32'(out_last), 32'(e.last));
          end
        end
      end
    end
  end

endmodule
